// File: rtl/nx4_pkg.sv
// nx4_pkg: shared constants, word types and small helpers for the NX4 LED sink.
package nx4_pkg;

  localparam int GS_BITS            = 12;
  localparam int DC_BITS            = 6;
  localparam int CH_PER_DRIVER      = 16;
  localparam int GS_BITS_PER_DRIVER = 192;
  localparam int DC_BITS_PER_DRIVER = 96;
  localparam int BIT_CNT_W          = 11;

  typedef logic [GS_BITS-1:0] gs_t;
  typedef logic [DC_BITS-1:0] dc_t;

  // Saturating increment of the shifted-bit counter (holds at 2047).
  function automatic logic [BIT_CNT_W-1:0] bit_cnt_inc(input logic [BIT_CNT_W-1:0] v);
    logic [BIT_CNT_W-1:0] r;
    if (v == 11'h7FF) begin
      r = v;
    end else begin
      r = v + 11'd1;
    end
    return r;
  endfunction

  // Saturating increment of the 12-bit grayscale PWM counter (holds at 4095).
  function automatic gs_t gs_cnt_inc(input gs_t v);
    gs_t r;
    if (v == 12'hFFF) begin
      r = v;
    end else begin
      r = v + 12'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/nx4_edge_detect.sv
// nx4_edge_detect: one monitored driver line -> sampled level plus rising-edge flag.
// With NX4_SINK_SYNC_EN defined the line first passes a 2-flop synchronizer;
// otherwise the line is taken directly because its source runs on this clock.
module nx4_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic line,
  output logic sample,
  output logic rise
);

  logic prev_r;

`ifdef NX4_SINK_SYNC_EN
  logic sync1_r;
  logic sync2_r;

  // Two-stage synchronizer for lines driven from another clock domain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= line;
      sync2_r <= sync1_r;
    end
  end

  assign sample = sync2_r;
`else
  assign sample = line;
`endif

  // Previous sample, so a 0->1 step between consecutive samples is an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= sample;
    end
  end

  assign rise = sample & ~prev_r;

endmodule

// File: rtl/nx4_led_sink.sv
// nx4_led_sink: receiving-end model of the NX4 LED driver chain. Rebuilds the
// latched grayscale / dot-correction registers from the serial stream, derives
// the per-channel PWM state and flags bit-count errors.
// Build option NX4_SINK_SYNC_EN adds a 2-flop synchronizer on every led_* line.
module nx4_led_sink
  import nx4_pkg::*;
#(
  parameter int CHAIN = 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              led_sclk,
  input  logic                              led_sin,
  input  logic                              led_mode,
  input  logic                              led_xlat,
  input  logic                              led_blank,
  input  logic                              led_gsclk,
  input  logic                              err_clear,
  input  logic [$clog2(CHAIN*16)-1:0]       rd_addr,
  output logic [11:0]                       rd_gs,
  output logic [5:0]                        rd_dc,
  output logic [CHAIN*16-1:0]               ch_on,
  output logic                              xlat_pulse,
  output logic                              len_err,
  output logic                              led_xerr,
  output logic [15:0]                       blank_count
);

  localparam int NCH = CHAIN * CH_PER_DRIVER;
  localparam int L   = CHAIN * GS_BITS_PER_DRIVER;
  localparam logic [BIT_CNT_W-1:0] GS_EXP = BIT_CNT_W'(CHAIN * GS_BITS_PER_DRIVER);
  localparam logic [BIT_CNT_W-1:0] DC_EXP = BIT_CNT_W'(CHAIN * DC_BITS_PER_DRIVER);

  // Sampled line levels and rising-edge flags.
  logic sclk_smp_s,  sclk_rise_s;
  logic sin_smp_s,   sin_rise_s;
  logic mode_smp_s,  mode_rise_s;
  logic xlat_smp_s,  xlat_rise_s;
  logic blank_smp_s, blank_rise_s;
  logic gsclk_smp_s, gsclk_rise_s;
  logic unused_s;

  logic [L-1:0]           sr_r;
  logic [L-1:0]           sr_next_s;
  logic [BIT_CNT_W-1:0]   bit_cnt_r;
  logic [BIT_CNT_W-1:0]   bit_cnt_next_s;
  logic                   cnt_bad_s;
  logic                   len_err_next_s;
  gs_t                    gs_r [NCH];
  dc_t                    dc_r [NCH];
  gs_t                    gs_cnt_r;
  logic                   xlat_pulse_r;
  logic                   len_err_r;
  logic                   led_xerr_r;
  logic [15:0]            blank_count_r;
  logic [11:0]            rd_gs_r;
  logic [5:0]             rd_dc_r;
  logic [NCH-1:0]         ch_on_s;

  nx4_edge_detect u_ed_sclk  (.clock(clock), .reset(reset), .line(led_sclk),  .sample(sclk_smp_s),  .rise(sclk_rise_s));
  nx4_edge_detect u_ed_sin   (.clock(clock), .reset(reset), .line(led_sin),   .sample(sin_smp_s),   .rise(sin_rise_s));
  nx4_edge_detect u_ed_mode  (.clock(clock), .reset(reset), .line(led_mode),  .sample(mode_smp_s),  .rise(mode_rise_s));
  nx4_edge_detect u_ed_xlat  (.clock(clock), .reset(reset), .line(led_xlat),  .sample(xlat_smp_s),  .rise(xlat_rise_s));
  nx4_edge_detect u_ed_blank (.clock(clock), .reset(reset), .line(led_blank), .sample(blank_smp_s), .rise(blank_rise_s));
  nx4_edge_detect u_ed_gsclk (.clock(clock), .reset(reset), .line(led_gsclk), .sample(gsclk_smp_s), .rise(gsclk_rise_s));

  // Only levels of sin/mode/blank and edges of sclk/xlat/blank/gsclk matter.
  assign unused_s = &{1'b0, sin_rise_s, mode_rise_s, sclk_smp_s, xlat_smp_s, gsclk_smp_s};

  // Next shift-register / bit-count values; the latch sees the post-shift view
  // so an sclk edge coinciding with xlat is included in both data and count.
  always_comb begin
    sr_next_s      = sr_r;
    bit_cnt_next_s = bit_cnt_r;
    if (sclk_rise_s) begin
      sr_next_s      = {sr_r[L-2:0], sin_smp_s};
      bit_cnt_next_s = bit_cnt_inc(bit_cnt_r);
    end else begin
      sr_next_s      = sr_r;
      bit_cnt_next_s = bit_cnt_r;
    end
    if (mode_smp_s) begin
      cnt_bad_s = (bit_cnt_next_s != DC_EXP);
    end else begin
      cnt_bad_s = (bit_cnt_next_s != GS_EXP);
    end
    if (xlat_rise_s && cnt_bad_s) begin
      len_err_next_s = 1'b1;
    end else if (err_clear) begin
      len_err_next_s = 1'b0;
    end else begin
      len_err_next_s = len_err_r;
    end
  end

  // Serial shift register, bit counter, latch strobe and error flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr_r         <= '0;
      bit_cnt_r    <= 11'd0;
      xlat_pulse_r <= 1'b0;
      len_err_r    <= 1'b0;
      led_xerr_r   <= 1'b1;
    end else begin
      sr_r         <= sr_next_s;
      if (xlat_rise_s) begin
        bit_cnt_r <= 11'd0;
      end else begin
        bit_cnt_r <= bit_cnt_next_s;
      end
      xlat_pulse_r <= xlat_rise_s;
      len_err_r    <= len_err_next_s;
      led_xerr_r   <= ~len_err_next_s;
    end
  end

  // Latched per-channel GS / DC words, loaded from the post-shift register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        gs_r[c] <= 12'h000;
        dc_r[c] <= 6'h3F;
      end
    end else if (xlat_rise_s) begin
      if (mode_smp_s) begin
        for (int c = 0; c < NCH; c++) begin
          dc_r[c] <= sr_next_s[DC_BITS*c +: DC_BITS];
        end
      end else begin
        for (int c = 0; c < NCH; c++) begin
          gs_r[c] <= sr_next_s[GS_BITS*c +: GS_BITS];
        end
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        gs_r[c] <= gs_r[c];
        dc_r[c] <= dc_r[c];
      end
    end
  end

  // Grayscale PWM counter: held at zero during blank, counts gsclk otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gs_cnt_r <= 12'h000;
    end else if (blank_smp_s) begin
      gs_cnt_r <= 12'h000;
    end else if (gsclk_rise_s) begin
      gs_cnt_r <= gs_cnt_inc(gs_cnt_r);
    end else begin
      gs_cnt_r <= gs_cnt_r;
    end
  end

  // Wrapping count of blank rising edges.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blank_count_r <= 16'd0;
    end else if (blank_rise_s) begin
      blank_count_r <= blank_count_r + 16'd1;
    end else begin
      blank_count_r <= blank_count_r;
    end
  end

  // Registered readout of the addressed channel.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_gs_r <= 12'h000;
      rd_dc_r <= 6'h3F;
    end else if (32'(rd_addr) < 32'(NCH)) begin
      rd_gs_r <= gs_r[rd_addr];
      rd_dc_r <= dc_r[rd_addr];
    end else begin
      rd_gs_r <= 12'h000;
      rd_dc_r <= 6'h3F;
    end
  end

  // Channel PWM state; follows the blank sample directly so outputs go dark
  // in the same cycle blank is seen.
  always_comb begin
    ch_on_s = '0;
    for (int c = 0; c < NCH; c++) begin
      ch_on_s[c] = ~blank_smp_s & (gs_cnt_r < gs_r[c]);
    end
  end

  assign rd_gs       = rd_gs_r;
  assign rd_dc       = rd_dc_r;
  assign ch_on       = ch_on_s;
  assign xlat_pulse  = xlat_pulse_r;
  assign len_err     = len_err_r;
  assign led_xerr    = led_xerr_r;
  assign blank_count = blank_count_r;

endmodule

// File: tb/tb_nx4_led_sink.sv
// tb_nx4_led_sink: directed plus randomized stimulus for nx4_led_sink (CHAIN=1,
// default build), checked against a bit-stream level reference model.
module tb_nx4_led_sink;

  logic        clock = 1'b0;
  logic        reset;
  logic        led_sclk, led_sin, led_mode, led_xlat, led_blank, led_gsclk;
  logic        err_clear;
  logic [3:0]  rd_addr;
  logic [11:0] rd_gs;
  logic [5:0]  rd_dc;
  logic [15:0] ch_on;
  logic        xlat_pulse, len_err, led_xerr;
  logic [15:0] blank_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: last 192 shifted bits (index 0 = oldest).
  bit          win[$];
  int          m_bitcnt;
  logic [11:0] m_gs [16];
  logic [5:0]  m_dc [16];
  bit          m_len;
  int          m_gscnt;
  bit          m_blank;
  int          m_bcnt;
  logic [11:0] w [16];

  nx4_led_sink #(.CHAIN(1)) dut (
    .clock(clock), .reset(reset),
    .led_sclk(led_sclk), .led_sin(led_sin), .led_mode(led_mode),
    .led_xlat(led_xlat), .led_blank(led_blank), .led_gsclk(led_gsclk),
    .err_clear(err_clear), .rd_addr(rd_addr),
    .rd_gs(rd_gs), .rd_dc(rd_dc), .ch_on(ch_on), .xlat_pulse(xlat_pulse),
    .len_err(len_err), .led_xerr(led_xerr), .blank_count(blank_count)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    win.delete();
    for (int i = 0; i < 192; i++) win.push_back(1'b0);
    m_bitcnt = 0; m_len = 1'b0; m_gscnt = 0; m_blank = 1'b0; m_bcnt = 0;
    for (int c = 0; c < 16; c++) begin
      m_gs[c] = 12'h000;
      m_dc[c] = 6'h3F;
    end
  endfunction

  function automatic void m_shift(input bit b);
    win.push_back(b);
    void'(win.pop_front());
    if (m_bitcnt < 2047) m_bitcnt++;
  endfunction

  // Channel 15 owns the oldest word of the window, MSB first; DC words live in
  // the newest 96 bits.
  function automatic void m_latch(input bit md);
    int exp_n;
    exp_n = md ? 96 : 192;
    if (m_bitcnt != exp_n) m_len = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (md) begin
        for (int k = 0; k < 6; k++) m_dc[c][5-k] = win[96 + (15-c)*6 + k];
      end else begin
        for (int k = 0; k < 12; k++) m_gs[c][11-k] = win[(15-c)*12 + k];
      end
    end
    m_bitcnt = 0;
  endfunction

  function automatic logic [15:0] m_chon();
    logic [15:0] r;
    for (int c = 0; c < 16; c++) r[c] = !m_blank && (m_gscnt < int'(m_gs[c]));
    return r;
  endfunction

  task automatic shift_bit(input bit b);
    led_sin = b; led_sclk = 1'b1;
    @(negedge clock);
    led_sclk = 1'b0;
    @(negedge clock);
    m_shift(b);
  endtask

  task automatic do_xlat(input bit md, input bit with_bit, input bit b);
    led_mode = md;
    if (with_bit) begin
      led_sin = b; led_sclk = 1'b1;
    end
    led_xlat = 1'b1;
    @(negedge clock);
    led_sclk = 1'b0; led_xlat = 1'b0;
    if (with_bit) m_shift(b);
    m_latch(md);
    check_val("xlat_pulse_hi", xlat_pulse, 1'b1);
    @(negedge clock);
    check_val("xlat_pulse_lo", xlat_pulse, 1'b0);
  endtask

  task automatic gsclk_pulse();
    led_gsclk = 1'b1;
    @(negedge clock);
    led_gsclk = 1'b0;
    @(negedge clock);
    if (!m_blank && m_gscnt < 4095) m_gscnt++;
  endtask

  task automatic set_blank(input bit v);
    led_blank = v;
    @(negedge clock);
    if (v && !m_blank) m_bcnt++;
    m_blank = v;
    if (v) m_gscnt = 0;
  endtask

  task automatic check_status(input string tag);
    check_val({tag, ".ch_on"}, ch_on, m_chon());
    check_val({tag, ".len_err"}, len_err, m_len);
    check_val({tag, ".led_xerr"}, led_xerr, !m_len);
    check_val({tag, ".blank_count"}, blank_count, m_bcnt[15:0]);
  endtask

  task automatic check_readout(input string tag);
    for (int a = 0; a < 16; a++) begin
      rd_addr = a[3:0];
      @(negedge clock);
      check_val($sformatf("%s.rd_gs[%0d]", tag, a), rd_gs, m_gs[a]);
      check_val($sformatf("%s.rd_dc[%0d]", tag, a), rd_dc, m_dc[a]);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, ".rd_gs"}, rd_gs, 12'h000);
    check_val({tag, ".rd_dc"}, rd_dc, 6'h3F);
    check_val({tag, ".ch_on"}, ch_on, 16'h0000);
    check_val({tag, ".xlat_pulse"}, xlat_pulse, 1'b0);
    check_val({tag, ".len_err"}, len_err, 1'b0);
    check_val({tag, ".led_xerr"}, led_xerr, 1'b1);
    check_val({tag, ".blank_count"}, blank_count, 16'd0);
  endtask

  task automatic send_gs_words();
    for (int c = 15; c >= 0; c--)
      for (int k = 11; k >= 0; k--) shift_bit(w[c][k]);
  endtask

  // Random-length load: n bits, last one optionally coinciding with xlat.
  task automatic rand_load(input bit md);
    int n;
    bit sim;
    n = md ? 96 : 192;
    if ($urandom_range(0, 3) == 0) n = n + $urandom_range(0, 6) - 3;
    sim = $urandom_range(0, 1) == 1;
    led_mode = md;
    for (int i = 0; i < n - (sim ? 1 : 0); i++) shift_bit($urandom_range(0, 1) == 1);
    do_xlat(md, sim, $urandom_range(0, 1) == 1);
  endtask

  initial begin
    reset = 1'b1;
    led_sclk = 1'b0; led_sin = 1'b0; led_mode = 1'b0; led_xlat = 1'b0;
    led_blank = 1'b0; led_gsclk = 1'b0; err_clear = 1'b0; rd_addr = 4'd0;
    m_reset();
    repeat (3) @(negedge clock);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clock);

    // GS load with channel 15 = FFF first, channel 0 = 001 last.
    for (int c = 0; c < 16; c++) w[c] = 12'($urandom_range(2, 4094));
    w[15] = 12'hFFF; w[0] = 12'h001;
    led_mode = 1'b0;
    send_gs_words();
    do_xlat(1'b0, 1'b0, 1'b0);
    check_status("gs_load");
    check_readout("gs_load");

    // PWM: channel 0 (gs=1) goes off after the first gsclk, channel 15 stays on.
    check_val("pwm.ch0_before", ch_on[0], 1'b1);
    gsclk_pulse();
    check_val("pwm.ch0_after", ch_on[0], 1'b0);
    gsclk_pulse();
    check_val("pwm.ch15", ch_on[15], 1'b1);
    check_status("pwm");
    set_blank(1'b1);
    check_val("blank.ch_on", ch_on, 16'h0000);
    check_val("blank.count", blank_count, 16'd1);
    gsclk_pulse();
    check_status("blank_gsclk");
    set_blank(1'b0);

    // DC load, all channels 6'h15; GS must stay as loaded.
    led_mode = 1'b1;
    for (int c = 0; c < 16; c++)
      for (int k = 5; k >= 0; k--) shift_bit((k % 2) == 0);
    do_xlat(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 16; c++) check_val("dc_load.model", m_dc[c], 6'h15);
    check_readout("dc_load");

    // Short GS load: error flagged, latch still happens, err_clear releases it.
    led_mode = 1'b0;
    for (int i = 0; i < 191; i++) shift_bit($urandom_range(0, 1) == 1);
    do_xlat(1'b0, 1'b0, 1'b0);
    check_val("len.len_err", len_err, 1'b1);
    check_val("len.led_xerr", led_xerr, 1'b0);
    check_readout("len");
    err_clear = 1'b1;
    @(negedge clock);
    err_clear = 1'b0;
    m_len = 1'b0;
    check_val("clr.len_err", len_err, 1'b0);
    check_val("clr.led_xerr", led_xerr, 1'b1);

    // 192nd sclk edge together with xlat.
    for (int c = 0; c < 16; c++) w[c] = 12'($urandom);
    w[0][0] = 1'b1;
    for (int c = 15; c >= 0; c--)
      for (int k = 11; k >= 0; k--)
        if (!(c == 0 && k == 0)) shift_bit(w[c][k]);
    do_xlat(1'b0, 1'b1, w[0][0]);
    check_val("sim.len_err", len_err, 1'b0);
    check_val("sim.model_gs0", m_gs[0], w[0]);
    check_readout("sim");

    // Randomized mix of loads, PWM activity, blanking and error clearing.
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 4))
        0: rand_load(1'b0);
        1: rand_load(1'b1);
        2: begin
          int np;
          np = $urandom_range(1, 12);
          for (int p = 0; p < np; p++) gsclk_pulse();
        end
        3: set_blank(!m_blank);
        default: begin
          err_clear = 1'b1;
          @(negedge clock);
          err_clear = 1'b0;
          m_len = 1'b0;
        end
      endcase
      check_status($sformatf("rnd%0d", it));
      if ((it % 6) == 5) check_readout($sformatf("rnd%0d", it));
    end

    // Reset after 100 bits of a new load.
    set_blank(1'b0);
    led_mode = 1'b0;
    for (int i = 0; i < 100; i++) shift_bit($urandom_range(0, 1) == 1);
    #2 reset = 1'b1;
    #1 m_reset();
    check_reset_vals("midreset");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_reset_vals("post_reset");
    for (int c = 0; c < 16; c++) w[c] = 12'($urandom);
    send_gs_words();
    do_xlat(1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 16; c++) check_val("reload.model", m_gs[c], w[c]);
    check_status("reload");
    check_readout("reload");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nx4_led_sink.md
# nx4_led_sink

Receiving-end model of the Barco NX4 LED driver chain; it sits on the same led_* lines the panel driver transmits. It watches the serial grayscale/dot-correction stream (sclk, sin, mode, xlat) plus the blank/gsclk PWM timing, oversampled in the system clock domain. It rebuilds the per-channel latched registers and the resulting channel on/off state, and it reports framing errors on an active-low xerr line. It is the bench and loopback counterpart to the panel driver.

## Interface
- CHAIN, 1: drivers in series on one sin line; 16 channels each.
- clock  in  1  system clock; all inputs sampled on its rising edge.
- reset  in  1  asynchronous, active-high.
- led_sclk, led_sin, led_mode, led_xlat, led_blank, led_gsclk  in  1 each  monitored driver lines.
- err_clear  in  1  synchronous clear of len_err.
- rd_addr  in  $clog2(CHAIN*16)  channel readout address.
- rd_gs  out  12  registered grayscale of rd_addr; reset 0.
- rd_dc  out  6  registered dot-correction of rd_addr; reset 6'h3F.
- ch_on  out  CHAIN*16  per-channel PWM state; reset 0.
- xlat_pulse  out  1  one-cycle strobe per latch; reset 0.
- len_err  out  1  sticky bit-count error; reset 0.
- led_xerr  out  1  active-low error, equals !len_err; reset 1.
- blank_count  out  16  count of blank rising edges, wraps; reset 0.

## Operation
- Edge detection: each line is registered, and a rising edge means the current sample is 1 and the previous sample is 0.
- On an sclk rising edge: sr <= {sr[L-2:0], sin_sample}, with L = CHAIN*192. bit_cnt increments and saturates at 2047.
- Bit mapping: global channel c takes GS = sr[12c+:12] and DC = sr[6c+:6]. The first word shifted goes to the highest channel, MSB first.
- On an xlat rising edge, the latched mode selects the target:
  - mode=0 copies all GS words.
  - mode=1 copies all DC words.
  - Both cases pulse xlat_pulse and clear bit_cnt.
  - If bit_cnt differs from the expected count (CHAIN*192 for mode 0, CHAIN*96 for mode 1), len_err is set. The latch is still performed.
- GS counter, 12 bits:
  - Cleared while blank=1.
  - Increments on each gsclk rising edge while blank=0.
  - Saturates at 4095.
- ch_on[c] = !blank_sample && (gs_cnt < gs[c]). DC has no effect on ch_on; it is readout only.
- err_clear clears len_err. If a new error occurs in the same cycle, the set wins.
- blank_count increments on each blank rising edge.

## Timing
- Without sync: an edge is detected, and its effect lands in registers, 1 cycle after the input change. rd_gs/rd_dc are valid 1 cycle after rd_addr.
- sclk and xlat edges in the same cycle: the shift happens first, the latch captures the post-shift register, and the count includes that bit.
- gsclk edge while blank=1: ignored. blank rising and gsclk in the same cycle: the counter clears.
- ch_on drops in the same cycle blank_sample rises.
- xlat edge with bit_cnt=0: the latch still happens, and len_err is set.
- Reset mid-stream: sr, bit_cnt, gs_cnt and all outputs return to reset values immediately. No partial latch occurs.

## Configuration
- NX4_SINK_SYNC_EN defined:
  - Every led_* input passes through a 2-flop synchronizer before edge detection.
  - All input-to-effect latencies grow by 2 cycles.
  - Use for asynchronous or external stimulus.
- Undefined: inputs are sampled directly, as required when the source is clocked by clock.

## Structure
- Package nx4_pkg holds:
  - GS_BITS=12, DC_BITS=6, CH_PER_DRIVER=16.
  - GS_BITS_PER_DRIVER=192, DC_BITS_PER_DRIVER=96.
  - typedefs gs_t and dc_t.
- Sub-module nx4_edge_detect covers one line: optional synchronizer, sampled value, and rising-edge flag. It is instantiated six times.

## Test plan
- GS load, CHAIN=1, mode=0: shift 192 bits with channel 15=12'hFFF first, channel 0=12'h001 last, then xlat. Required: one xlat_pulse; rd_addr=15 gives rd_gs=12'hFFF; rd_addr=0 gives 12'h001; len_err=0.
- PWM: with the above latched, drop blank and issue 2 gsclk edges. Required:
  - ch_on[0]=1 before the first edge and 0 after it.
  - ch_on[15]=1.
  - Raise blank: all ch_on=0, and blank_count goes 0->1.
- DC load: mode=1, 96 bits all 6'h15, xlat. Required: rd_dc=6'h15 for every address; rd_gs unchanged.
- Length error: 191 bits then xlat with mode=0. Required: len_err=1, led_xerr=0, latch still updated. Assert err_clear for 1 cycle: len_err=0, led_xerr=1.
- Simultaneous edges: the 192nd sclk edge coincides with the xlat edge. Required: len_err=0, and the latched value includes the final bit.
- Async reset after 100 bits: all outputs at reset values. A subsequent clean 192-bit load latches correctly with len_err=0.
